// File: rtl/cache_snoop_responder_if.sv
// Snoop-side bundle for cache_snoop_responder: bus request/response channel
// plus the tag-table snoop lookup port and the shared table write port.
// The responder takes the slave view; the bus and table side take the master view.
interface cache_snoop_responder_if #(
    parameter int ENTRY_WIDTH  = 10,
    parameter int FLAG_WIDTH   = 2,
    parameter int ADDR_P_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_P_WIDTH-1:0] req_addr;
    logic                    req_inval;

    logic [ADDR_P_WIDTH-1:0] snp_addr;
    logic                    snp_match;
    logic [FLAG_WIDTH-1:0]   snp_flag;
    logic [ENTRY_WIDTH-1:0]  snp_index;

    logic                    upd_req;
    logic                    upd_gnt;
    logic [ENTRY_WIDTH-1:0]  tbl_index;
    logic                    tbl_we_flag;
    logic [FLAG_WIDTH-1:0]   tbl_new_flag;

    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_hit;
    logic                    resp_dirty;
    logic [ENTRY_WIDTH-1:0]  resp_index;
    logic                    resp_err;

    modport slave (
        input  req_valid, req_addr, req_inval,
        input  snp_match, snp_flag, snp_index,
        input  upd_gnt, resp_ready,
        output req_ready, snp_addr, upd_req, tbl_index, tbl_we_flag, tbl_new_flag,
        output resp_valid, resp_hit, resp_dirty, resp_index, resp_err
    );

    modport master (
        output req_valid, req_addr, req_inval,
        output snp_match, snp_flag, snp_index,
        output upd_gnt, resp_ready,
        input  req_ready, snp_addr, upd_req, tbl_index, tbl_we_flag, tbl_new_flag,
        input  resp_valid, resp_hit, resp_dirty, resp_index, resp_err
    );
endinterface

// File: rtl/cache_snoop_responder.sv
// Snoop responder in front of cache_tag_table. Takes one bus snoop at a time,
// looks the line up, applies the MOESI-lite downgrade/invalidate through the
// shared table write port, and answers with hit/dirty/index (or a grant-timeout error).
module cache_snoop_responder #(
    parameter int ENTRY_WIDTH  = 10,
    parameter int FLAG_WIDTH   = 2,
    parameter int ADDR_P_WIDTH = 32,
    parameter int GNT_TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_snoop_responder_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST          = CNT_WIDTH'(GNT_TIMEOUT - 1);
    localparam logic [FLAG_WIDTH-1:0] FLAG_INVALID      = FLAG_WIDTH'(0);
    localparam logic [FLAG_WIDTH-1:0] FLAG_SHARED_CLEAN = FLAG_WIDTH'(1);
    localparam logic [FLAG_WIDTH-1:0] FLAG_OWNED_CLEAN  = FLAG_WIDTH'(2);
    localparam logic [FLAG_WIDTH-1:0] FLAG_OWNED_DIRTY  = FLAG_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_RESP
    } state_t;

    state_t                  r_state,      w_state_nxt;
    logic [ADDR_P_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic                    r_inval,      w_inval_nxt;
    logic [ENTRY_WIDTH-1:0]  r_index,      w_index_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt,        w_cnt_nxt;
    logic                    r_resp_hit,   w_resp_hit_nxt;
    logic                    r_resp_dirty, w_resp_dirty_nxt;
    logic [ENTRY_WIDTH-1:0]  r_resp_index, w_resp_index_nxt;
    logic                    r_resp_err,   w_resp_err_nxt;

    // Live view of the table entry; also re-evaluated in UPDATE because the
    // CPU side may have changed the line while we waited for the write port.
    logic                    w_live_hit;
    logic                    w_live_dirty;
    logic                    w_live_write;
    logic [FLAG_WIDTH-1:0]   w_live_new_flag;
    logic [ENTRY_WIDTH-1:0]  w_live_index;

    // Decode the snooped entry against the registered snoop kind
    always_comb begin
        w_live_hit      = bus.snp_match && (bus.snp_flag != FLAG_INVALID);
        w_live_dirty    = w_live_hit && (bus.snp_flag == FLAG_OWNED_DIRTY);
        w_live_write    = w_live_hit && (r_inval || (bus.snp_flag == FLAG_OWNED_CLEAN) ||
                                         (bus.snp_flag == FLAG_OWNED_DIRTY));
        w_live_new_flag = r_inval ? FLAG_INVALID : FLAG_SHARED_CLEAN;
        w_live_index    = w_live_hit ? bus.snp_index : '0;
    end

    // Next-state, transaction registers and all interface outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_inval_nxt      = r_inval;
        w_index_nxt      = r_index;
        w_cnt_nxt        = r_cnt;
        w_resp_hit_nxt   = r_resp_hit;
        w_resp_dirty_nxt = r_resp_dirty;
        w_resp_index_nxt = r_resp_index;
        w_resp_err_nxt   = r_resp_err;

        bus.req_ready    = 1'b0;
        bus.snp_addr     = '0;
        bus.upd_req      = 1'b0;
        bus.tbl_index    = '0;
        bus.tbl_we_flag  = 1'b0;
        bus.tbl_new_flag = '0;
        bus.resp_valid   = 1'b0;
        bus.resp_hit     = r_resp_hit;
        bus.resp_dirty   = r_resp_dirty;
        bus.resp_index   = r_resp_index;
        bus.resp_err     = r_resp_err;

        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_addr_nxt  = bus.req_addr;
                    w_inval_nxt = bus.req_inval;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                bus.snp_addr = r_addr;
                if (w_live_write) begin
                    w_index_nxt = bus.snp_index;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_UPDATE;
                end else begin
                    w_resp_hit_nxt   = w_live_hit;
                    w_resp_dirty_nxt = w_live_dirty;
                    w_resp_index_nxt = w_live_index;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = ST_RESP;
                end
            end
            ST_UPDATE: begin
                bus.snp_addr  = r_addr;
                bus.upd_req   = 1'b1;
                bus.tbl_index = r_index;
                if (bus.upd_gnt) begin
                    bus.tbl_we_flag  = w_live_write;
                    bus.tbl_new_flag = w_live_write ? w_live_new_flag : '0;
                    w_resp_hit_nxt   = w_live_hit;
                    w_resp_dirty_nxt = w_live_dirty;
                    w_resp_index_nxt = w_live_index;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_resp_hit_nxt   = 1'b0;
                    w_resp_dirty_nxt = 1'b0;
                    w_resp_index_nxt = '0;
                    w_resp_err_nxt   = 1'b1;
                    w_state_nxt      = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                bus.snp_addr   = r_addr;
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_resp_hit_nxt   = 1'b0;
                    w_resp_dirty_nxt = 1'b0;
                    w_resp_index_nxt = '0;
                    w_resp_err_nxt   = 1'b0;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_inval      <= 1'b0;
            r_index      <= '0;
            r_cnt        <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_dirty <= 1'b0;
            r_resp_index <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_inval      <= w_inval_nxt;
            r_index      <= w_index_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_hit   <= w_resp_hit_nxt;
            r_resp_dirty <= w_resp_dirty_nxt;
            r_resp_index <= w_resp_index_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end
endmodule
